// File: rtl/wb_regfile.sv
// Writeback-stage register file: one-entry writeback latch feeding a 16-entry array.
// Optional read bypass of the pending write is enabled by WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_dest,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    output logic              o_pend_valid,
    output logic [ADDR_W-1:0] o_pend_dest,
    output logic              o_commit_valid,
    output logic [ADDR_W-1:0] o_commit_dest,
    output logic [CNT_W-1:0]  o_wr_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_dest;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_commit_valid;
    logic [ADDR_W-1:0] r_commit_dest;
    logic [CNT_W-1:0]  r_wr_count;
    logic              w_capture;

    // R0 is hardwired to zero, so writes to it are dropped before the latch.
    assign w_capture = i_wb_we & ~i_stall & ~i_flush & (i_wb_dest != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend_valid   <= 1'b0;
            r_pend_dest    <= '0;
            r_pend_data    <= '0;
            r_commit_valid <= 1'b0;
            r_commit_dest  <= '0;
            r_wr_count     <= '0;
        end else begin
            r_pend_valid <= w_capture;
            if (w_capture) begin
                r_pend_dest <= i_wb_dest;
                r_pend_data <= i_wb_data;
            end
            // An already-latched write is older than any stalled/flushed one and always retires.
            if (r_pend_valid) begin
                r_regs[r_pend_dest] <= r_pend_data;
                r_commit_valid      <= 1'b1;
                r_commit_dest       <= r_pend_dest;
                r_wr_count          <= r_wr_count + CNT_W'(1);
            end else begin
                r_commit_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rd_data_a = '0;
        o_rd_data_b = '0;
        if (i_rd_addr_a != '0) begin
            o_rd_data_a = r_regs[i_rd_addr_a];
`ifdef WB_REGFILE_BYPASS_EN
            if (r_pend_valid && (i_rd_addr_a == r_pend_dest)) begin
                o_rd_data_a = r_pend_data;
            end
`endif
        end
        if (i_rd_addr_b != '0) begin
            o_rd_data_b = r_regs[i_rd_addr_b];
`ifdef WB_REGFILE_BYPASS_EN
            if (r_pend_valid && (i_rd_addr_b == r_pend_dest)) begin
                o_rd_data_b = r_pend_data;
            end
`endif
        end
    end

    assign o_pend_valid   = r_pend_valid;
    assign o_pend_dest    = r_pend_dest;
    assign o_commit_valid = r_commit_valid;
    assign o_commit_dest  = r_commit_dest;
    assign o_wr_count     = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: latency, stall/flush, R0, ordering,
// dual reads, async reset and retired-write counter wrap.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        stall;
    logic        flush;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        pend_valid;
    logic [3:0]  pend_dest;
    logic        commit_valid;
    logic [3:0]  commit_dest;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wb_we       (wb_we),
        .i_wb_dest     (wb_dest),
        .i_wb_data     (wb_data),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_rd_addr_a   (rd_addr_a),
        .i_rd_addr_b   (rd_addr_b),
        .o_rd_data_a   (rd_data_a),
        .o_rd_data_b   (rd_data_b),
        .o_pend_valid  (pend_valid),
        .o_pend_dest   (pend_dest),
        .o_commit_valid(commit_valid),
        .o_commit_dest (commit_dest),
        .o_wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] dest, input logic [15:0] data);
        wb_we   = we;
        wb_dest = dest;
        wb_data = data;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        rd_addr_a = 4'd3; rd_addr_b = 4'd0;
        drive(1'b1, 4'd3, 16'hBEEF);

        // reset held while a write is requested
        repeat (3) tick();
        check("rst_rd_a", rd_data_a, 0);
        check("rst_pend_valid", pend_valid, 0);
        check("rst_pend_dest", pend_dest, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_commit_valid", commit_valid, 0);

        rst_n = 1'b1;
        tick();
        check("rel_pend_valid", pend_valid, 1);
        check("rel_pend_dest", pend_dest, 3);
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        check("rel_rd_a", rd_data_a, 16'hBEEF);
        check("rel_wr_count", wr_count, 1);
        check("rel_commit_valid", commit_valid, 1);
        check("rel_commit_dest", commit_dest, 3);
        tick();
        check("idle_commit_valid", commit_valid, 0);
        check("idle_commit_dest_hold", commit_dest, 3);

        // latency / bypass on R5
        rd_addr_a = 4'd5;
        drive(1'b1, 4'd5, 16'h1234);
        tick();
        drive(1'b0, 4'd0, 16'h0000);
        check("lat_rd_a_pending", rd_data_a, BYP ? 16'h1234 : 16'h0000);
        check("lat_pend_dest", pend_dest, 5);
        tick();
        check("lat_rd_a_commit", rd_data_a, 16'h1234);
        check("lat_commit_valid", commit_valid, 1);
        check("lat_commit_dest", commit_dest, 5);
        check("lat_wr_count", wr_count, 2);
        tick();
        check("lat_commit_pulse", commit_valid, 0);

        // stall blocks capture
        rd_addr_a = 4'd2;
        stall = 1'b1;
        drive(1'b1, 4'd2, 16'hAAAA);
        tick();
        check("stall_pend_valid", pend_valid, 0);
        stall = 1'b0;
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        check("stall_rd_a", rd_data_a, 0);
        check("stall_wr_count", wr_count, 2);

        // latched write retires through a flush of the next one
        drive(1'b1, 4'd2, 16'h5555);
        tick();
        flush = 1'b1;
        drive(1'b1, 4'd2, 16'h7777);
        tick();
        check("flush_pend_valid", pend_valid, 0);
        check("flush_rd_a", rd_data_a, 16'h5555);
        flush = 1'b0;
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        check("flush_rd_a_after", rd_data_a, 16'h5555);
        check("flush_wr_count", wr_count, 3);

        // stall and flush together
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 4'd2, 16'h1111);
        tick();
        check("sf_pend_valid", pend_valid, 0);
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        check("sf_rd_a", rd_data_a, 16'h5555);
        check("sf_wr_count", wr_count, 3);

        // R0 writes are dropped
        rd_addr_a = 4'd0;
        drive(1'b1, 4'd0, 16'hFFFF);
        tick();
        check("r0_pend_valid", pend_valid, 0);
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        check("r0_rd_a", rd_data_a, 0);
        check("r0_wr_count", wr_count, 3);

        // back-to-back writes to R7
        rd_addr_a = 4'd7;
        drive(1'b1, 4'd7, 16'h0001);
        tick();
        drive(1'b1, 4'd7, 16'h0002);
        tick();
        drive(1'b1, 4'd7, 16'h0003);
        tick();
        check("b2b_rd_a_mid", rd_data_a, BYP ? 16'h0003 : 16'h0002);
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        check("b2b_rd_a", rd_data_a, 16'h0003);
        check("b2b_wr_count", wr_count, 6);

        // dual read ports
        drive(1'b1, 4'd1, 16'h0011);
        tick();
        drive(1'b1, 4'd4, 16'h0044);
        tick();
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        rd_addr_a = 4'd1; rd_addr_b = 4'd4;
        #1;
        check("dual_rd_a", rd_data_a, 16'h0011);
        check("dual_rd_b", rd_data_b, 16'h0044);
        rd_addr_a = 4'd4;
        #1;
        check("same_rd_a", rd_data_a, 16'h0044);
        check("same_rd_b", rd_data_b, 16'h0044);
        check("dual_wr_count", wr_count, 8);

        // async reset with a pending write
        rd_addr_a = 4'd9; rd_addr_b = 4'd1;
        drive(1'b1, 4'd9, 16'h9999);
        tick();
        check("arst_pend_before", pend_valid, 1);
        drive(1'b0, 4'd0, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pend_valid", pend_valid, 0);
        check("arst_wr_count", wr_count, 0);
        check("arst_rd_b", rd_data_b, 0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_commit_valid", commit_valid, 0);
        check("arst_rd_a", rd_data_a, 0);
        check("arst_wr_count_rel", wr_count, 0);

        // counter wrap: 65536 captures, last commit lands after we drops
        rd_addr_a = 4'd6;
        drive(1'b1, 4'd6, 16'h6666);
        repeat (65536) @(posedge clk);
        #1;
        check("wrap_wr_count_max", wr_count, 16'hFFFF);
        drive(1'b0, 4'd0, 16'h0000);
        tick();
        check("wrap_wr_count_zero", wr_count, 16'h0000);
        check("wrap_commit_valid", commit_valid, 1);
        check("wrap_rd_a", rd_data_a, 16'h6666);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage register file for the 16-bit Hydra datapath.
- Sits directly downstream of the writeback-data select mux. It latches the selected write data (ALU / mem / data_rg / mem_rg / imm result) with its destination into a one-entry writeback latch, then commits it to the register array on the following edge.
- Supplies two combinational read ports to decode, plus pending-write status for the hazard unit.

Parameters:
- DATA_W, 16, register and write-data width
- ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W (16)
- CNT_W, 16, width of retired-write counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  write request this cycle (from control)
- wb_dest  in  ADDR_W  destination register index
- wb_data  in  DATA_W  write data (writeback mux output)
- stall  in  1  hold: do not capture wb_* this cycle
- flush  in  1  squash: discard wb_* this cycle
- rd_addr_a  in  ADDR_W  read port A index
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- pend_valid  out  1  writeback latch holds an uncommitted write
- pend_dest  out  ADDR_W  destination of pending write
- commit_valid  out  1  registered: a write committed at last edge
- commit_dest  out  ADDR_W  registered: index committed at last edge
- wr_count  out  CNT_W  number of committed writes, wraps modulo 2**CNT_W

Behaviour:
- Reset (rst_n low, asynchronous):
  - all NUM_REGS array entries = 0
  - pend_valid = 0, pend_dest = 0, pend_data = 0
  - commit_valid = 0, commit_dest = 0, wr_count = 0
  - Reset asserted mid-operation discards any pending write. No commit occurs on the edge at which reset is released if pend_valid was cleared.
- Capture: at a rising edge, capture = wb_we & ~stall & ~flush & (wb_dest != 0).
  - capture=1: pend_valid <= 1, pend_dest <= wb_dest, pend_data <= wb_data
  - capture=0: pend_valid <= 0
- Commit: at the same edge, if pend_valid = 1:
  - array[pend_dest] <= pend_data
  - commit_valid <= 1, commit_dest <= pend_dest, wr_count <= wr_count + 1
  - otherwise commit_valid <= 0 and commit_dest holds its value
- Commit ordering:
  - Commit is independent of stall/flush: an already-latched write always retires, because it is older than the stalled or flushed instruction.
  - Back-to-back writes to the same register commit in order, one per cycle; the latest value wins.
- Latency: wb_* sampled at edge N → pend_valid during cycle N..N+1 → visible in array after edge N+1, two edges total.
- R0: reads always 0. Writes with wb_dest = 0 are never captured, so pend_valid stays 0 and wr_count does not increment.
- stall & flush both high: flush wins; no capture.
- Reads: rd_data_x = 0 if rd_addr_x = 0; otherwise array[rd_addr_x], unless bypass applies (see Optional Feature). Both ports may address the same register.
- wr_count wrap: 0xFFFF + 1 → 0x0000, no flag.
- No X propagation: all outputs are defined after reset regardless of input X on idle ports.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN
- Defined:
  - Read ports forward pend_data when pend_valid = 1 and rd_addr_x == pend_dest (rd_addr_x != 0), so decode sees the result one cycle early.
  - pend_valid/pend_dest remain outputs but the hazard unit needs no stall for this case.
- Undefined:
  - Reads return array contents only; a read of pend_dest returns the stale value until after the commit edge.
  - The hazard unit must stall on a pend_dest match.

Test Plan:
- Reset: hold rst_n=0, drive wb_we=1 wb_dest=3 wb_data=0xBEEF for 3 cycles → all reads 0, pend_valid=0, wr_count=0. Release rst_n → after 2 edges rd_data_a(addr 3)=0xBEEF, wr_count=1.
- Latency/bypass: write R5=0x1234 at edge N, read A=5.
  - Cycle N..N+1: 0x1234 with BYPASS_EN defined, old value (0) without.
  - After edge N+1: 0x1234 in both builds; commit_valid=1, commit_dest=5 for one cycle.
- Stall/flush:
  - Write R2=0xAAAA with stall=1 → not captured, R2 stays 0.
  - Write R2=0x5555 then flush=1 next cycle with wb_we=1 R2=0x7777 → R2=0x5555; wr_count +1 only.
  - stall=flush=1 → no capture.
- R0 and back-to-back: write R0=0xFFFF → reads 0, wr_count unchanged. Writes R7=0x0001, 0x0002, 0x0003 on consecutive edges → R7=0x0003 after final commit, wr_count +3.
- Dual read / wrap: preload R1=0x0011, R4=0x0044; A=1, B=4 → 0x0011/0x0044; A=B=4 → both 0x0044. Force 0xFFFF commits then one more → wr_count=0x0000.
- Async reset mid-operation: assert rst_n low between edges with pend_valid=1 (R9=0x9999) → pend_valid=0 immediately, R9=0 after release, no commit.
